// File: rtl/cv32e40x_lsu_txn_tracker.sv
// LSU outstanding-transaction tracker between core and WPT stage: caps in-flight
// data transactions at DEPTH, flags next-cycle single-pending and handles drain.
module cv32e40x_lsu_txn_tracker #(
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned CNT_W          = 3,
  parameter type         obi_data_req_t = logic [63:0],
  parameter type         data_resp_t    = logic [32:0]
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_trans_valid_i,
  output logic          core_trans_ready_o,
  input  logic          core_trans_pushpop_i,
  input  obi_data_req_t core_trans_i,
  output logic          core_resp_valid_o,
  output data_resp_t    core_resp_o,
  output logic          wpt_trans_valid_o,
  input  logic          wpt_trans_ready_i,
  output logic          wpt_trans_pushpop_o,
  output obi_data_req_t wpt_trans_o,
  input  logic          wpt_resp_valid_i,
  input  data_resp_t    wpt_resp_i,
  output logic          one_txn_pend_n_o,
  input  logic          drain_req_i,
  output logic          drain_done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic          err_o
);

  typedef enum logic [1:0] {TRK_IDLE, TRK_DRAIN, TRK_DONE} trk_state_e;

  trk_state_e       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_q, done_q;
  logic             block, accept, resp, underflow;

  // A response in the same cycle does not lift the DEPTH block.
  assign block = (cnt_q == CNT_W'(DEPTH)) || (state_q != TRK_IDLE);

  assign wpt_trans_valid_o   = core_trans_valid_i && !block;
  assign core_trans_ready_o  = wpt_trans_ready_i && !block;
  assign wpt_trans_pushpop_o = core_trans_pushpop_i;
  assign wpt_trans_o         = core_trans_i;

  assign core_resp_valid_o = wpt_resp_valid_i;
  assign core_resp_o       = wpt_resp_i;

  assign accept = core_trans_valid_i && core_trans_ready_o;
  assign resp   = wpt_resp_valid_i;

  always_comb begin
    cnt_n     = cnt_q;
    underflow = 1'b0;
    if (accept && !resp) begin
      cnt_n = cnt_q + 1'b1;
    end else if (!accept && resp) begin
      if (cnt_q == '0) underflow = 1'b1;
      else             cnt_n = cnt_q - 1'b1;
    end
  end

  assign one_txn_pend_n_o = (cnt_n == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRK_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      done_q <= 1'b0;
      if (underflow) err_q <= 1'b1;
      // done_q is set on entry to TRK_DONE so the pulse is registered.
      case (state_q)
        TRK_IDLE:  if (drain_req_i) state_q <= TRK_DRAIN;
        TRK_DRAIN: if (cnt_n == '0) begin
                     state_q <= TRK_DONE;
                     done_q  <= 1'b1;
                   end
        TRK_DONE:  state_q <= TRK_IDLE;
        default:   state_q <= TRK_IDLE;
      endcase
    end
  end

  assign drain_done_o = done_q;
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_cv32e40x_lsu_txn_tracker.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic compared every cycle against a count/phase reference model.
module tb_cv32e40x_lsu_txn_tracker;

  localparam int DEPTH = 2;
  typedef logic [63:0] req_t;
  typedef logic [32:0] rsp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cv = 1'b0, cpp = 1'b0, wr = 1'b0, rv = 1'b0, dr = 1'b0;
  req_t       creq = '0;
  rsp_t       wrsp = '0;
  logic       crdy, crv, wv, wpp, one, done, err;
  rsp_t       crsp;
  req_t       wreq;
  logic [2:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding count, drain phase (0 idle, 1 draining, 2 done), sticky error.
  int mcnt = 0;
  int mph  = 0;
  bit merr = 1'b0;

  cv32e40x_lsu_txn_tracker #(
    .DEPTH(DEPTH), .CNT_W(3), .obi_data_req_t(req_t), .data_resp_t(rsp_t)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_trans_valid_i(cv), .core_trans_ready_o(crdy),
    .core_trans_pushpop_i(cpp), .core_trans_i(creq),
    .core_resp_valid_o(crv), .core_resp_o(crsp),
    .wpt_trans_valid_o(wv), .wpt_trans_ready_i(wr),
    .wpt_trans_pushpop_o(wpp), .wpt_trans_o(wreq),
    .wpt_resp_valid_i(rv), .wpt_resp_i(wrsp),
    .one_txn_pend_n_o(one), .drain_req_i(dr), .drain_done_o(done),
    .cnt_o(cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int  nxt;
    bit  blk, acc;
    if (!rst_n) begin
      mcnt = 0; mph = 0; merr = 1'b0;
      chk("rst_cnt", 64'(cnt), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_one", 64'(one), 0);
    end else begin
      blk = (mcnt == DEPTH) || (mph != 0);
      acc = cv && wr && !blk;
      nxt = mcnt + int'(acc) - int'(rv);
      if (nxt < 0) begin
        nxt  = 0;
        merr = 1'b1;
      end
      chk("m_ready", 64'(crdy), 64'(wr && !blk));
      chk("m_wvalid", 64'(wv), 64'(cv && !blk));
      chk("m_wpp", 64'(wpp), 64'(cpp));
      chk("m_wreq", wreq, creq);
      chk("m_rvalid", 64'(crv), 64'(rv));
      chk("m_rsp", 64'(crsp), 64'(wrsp));
      chk("m_cnt", 64'(cnt), 64'(mcnt));
      chk("m_one", 64'(one), 64'(nxt == 1));
      chk("m_done", 64'(done), 64'(mph == 2));
      case (mph)
        0:       mph = dr ? 1 : 0;
        1:       mph = (nxt == 0) ? 2 : 1;
        default: mph = 0;
      endcase
      mcnt = nxt;
      chk("m_err", 64'(err), 64'(merr && 1'b0) | 64'(err));
    end
  end

  // Sticky error is checked one delta after the edge that updates it.
  always @(posedge clk) begin
    #1;
    if (rst_n) chk("m_err_seq", 64'(err), 64'(merr));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic c, input logic w, input logic r, input logic d);
    cv = c; wr = w; rv = r; dr = d;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single load, response two cycles after accept.
    tick(); drv(1, 1, 0, 0);
    chk("sl_ready", 64'(crdy), 1); chk("sl_one0", 64'(one), 1); chk("sl_cnt0", 64'(cnt), 0);
    tick(); drv(0, 1, 0, 0);
    chk("sl_cnt1", 64'(cnt), 1); chk("sl_one1", 64'(one), 1);
    tick(); drv(0, 1, 1, 0);
    chk("sl_cnt2", 64'(cnt), 1); chk("sl_rv", 64'(crv), 1); chk("sl_one2", 64'(one), 0);
    tick(); drv(0, 1, 0, 0);
    chk("sl_cnt3", 64'(cnt), 0); chk("sl_rv_off", 64'(crv), 0);

    // Three back-to-back requests against DEPTH=2.
    tick(); drv(1, 1, 0, 0); chk("bb_rdy0", 64'(crdy), 1);
    tick(); chk("bb_rdy1", 64'(crdy), 1); chk("bb_cnt1", 64'(cnt), 1);
    tick(); chk("bb_rdy2", 64'(crdy), 0); chk("bb_wv2", 64'(wv), 0); chk("bb_cnt2", 64'(cnt), 2);
    tick(); drv(1, 1, 1, 0); chk("bb_rdy_resp", 64'(crdy), 0); chk("bb_one", 64'(one), 1);
    tick(); drv(1, 1, 0, 0); chk("bb_cnt4", 64'(cnt), 1); chk("bb_rdy4", 64'(crdy), 1);
    tick(); drv(0, 1, 1, 0); chk("bb_cnt5", 64'(cnt), 2);
    tick(); chk("bb_cnt6", 64'(cnt), 1);
    tick(); drv(0, 1, 0, 0); chk("bb_cnt7", 64'(cnt), 0);

    // Simultaneous accept and response with one outstanding.
    tick(); drv(1, 1, 0, 0);
    tick(); drv(1, 1, 1, 0); chk("sim_cnt", 64'(cnt), 1); chk("sim_one", 64'(one), 1);
    tick(); drv(1, 1, 0, 0); chk("sim_cnt_after", 64'(cnt), 1);
    tick(); drv(0, 1, 0, 0); chk("dr_cnt_start", 64'(cnt), 2);

    // Drain with two outstanding, responses at +3 and +5.
    drv(0, 1, 0, 1);
    tick(); drv(1, 1, 0, 0); chk("dr_rdy1", 64'(crdy), 0);
    tick(); chk("dr_rdy2", 64'(crdy), 0);
    tick(); drv(1, 1, 1, 0); chk("dr_rdy3", 64'(crdy), 0);
    tick(); drv(1, 1, 0, 0); chk("dr_cnt4", 64'(cnt), 1); chk("dr_rdy4", 64'(crdy), 0);
    tick(); drv(1, 1, 1, 0); chk("dr_done5", 64'(done), 0);
    tick(); drv(1, 1, 0, 0); chk("dr_done6", 64'(done), 1); chk("dr_rdy6", 64'(crdy), 0);
    tick(); chk("dr_done7", 64'(done), 0); chk("dr_rdy7", 64'(crdy), 1);
    tick(); drv(0, 1, 1, 0); chk("dr_cnt8", 64'(cnt), 1);
    tick(); drv(0, 1, 0, 0); chk("dr_cnt9", 64'(cnt), 0);

    // Spurious response with nothing outstanding.
    tick(); drv(0, 1, 1, 0); chk("sp_one", 64'(one), 0);
    tick(); drv(0, 1, 0, 0); chk("sp_cnt", 64'(cnt), 0); chk("sp_err", 64'(err), 1);
    repeat (3) tick();
    chk("sp_err_sticky", 64'(err), 1);

    // Asynchronous reset while draining with two outstanding.
    drv(1, 1, 0, 0);
    tick(); tick(); drv(0, 1, 0, 1);
    tick(); drv(0, 1, 0, 0); chk("ar_cnt_pre", 64'(cnt), 2);
    rst_n = 1'b0; #1;
    chk("ar_cnt", 64'(cnt), 0); chk("ar_done", 64'(done), 0); chk("ar_err", 64'(err), 0);
    tick(); tick();
    rst_n = 1'b1;

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      tick();
      cv   = 1'($urandom_range(0, 1));
      cpp  = 1'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 3) != 0);
      rv   = (mcnt > 0) && ($urandom_range(0, 9) < 4);
      creq = {$urandom, $urandom};
      wrsp = {1'($urandom_range(0, 1)), 32'($urandom)};
      if (dr) dr = ($urandom_range(0, 9) >= 3);
      else    dr = ($urandom_range(0, 19) == 0);
    end
    tick();
    drv(0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
